// File: rtl/sync_fifo_prog.sv
// ---------------------------------------------------------------------------
// sync_fifo_prog
//   Single-clock FIFO with a power-of-two depth, an occupancy count,
//   programmable almost-full / almost-empty thresholds, a synchronous flush
//   and registered read data. It is meant for producer/consumer stages that
//   share one clock, so there are no pointer synchronisers.
//
// Optional build macro:
//   SYNC_FIFO_ERR_FLAGS_EN - adds the err_clr input and the sticky overflow
//                            and underflow outputs.
//
// Parameters:
//   DSIZE     - data width in bits
//   ASIZE     - address width; depth = 2**ASIZE entries
//   AFULL_TH  - almost_full when count >= AFULL_TH  (1 .. 2**ASIZE)
//   AEMPTY_TH - almost_empty when count <= AEMPTY_TH (0 .. 2**ASIZE-1)
//
// Ports:
//   clk          - clock; all state updates on the rising edge
//   rst_n        - asynchronous active-low reset
//   wdata        - write data
//   winc         - write request
//   rinc         - read request
//   flush        - synchronous clear of pointers/count (rdata is kept)
//   err_clr      - clears overflow/underflow        (macro builds only)
//   overflow     - sticky: a write was dropped       (macro builds only)
//   underflow    - sticky: a read was ignored        (macro builds only)
//   rdata        - registered read data, valid the cycle after a read
//   wfull        - FIFO holds 2**ASIZE entries
//   rempty       - FIFO holds 0 entries
//   almost_full  - count >= AFULL_TH
//   almost_empty - count <= AEMPTY_TH
//   count        - current occupancy, 0 .. 2**ASIZE
// ---------------------------------------------------------------------------
module sync_fifo_prog #(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned ASIZE     = 6,
  parameter int unsigned AFULL_TH  = 56,
  parameter int unsigned AEMPTY_TH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DSIZE-1:0] wdata,
  input  logic             winc,
  input  logic             rinc,
  input  logic             flush,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
  input  logic             err_clr,
  output logic             overflow,
  output logic             underflow,
`endif
  output logic [DSIZE-1:0] rdata,
  output logic             wfull,
  output logic             rempty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [ASIZE:0]   count
);

  localparam int unsigned DEPTH = 1 << ASIZE;

  // Constants sized to the pointer/count width so every compare and
  // increment is width-matched.
  localparam logic [ASIZE:0] ONE_C     = {{ASIZE{1'b0}}, 1'b1};
  localparam logic [ASIZE:0] DEPTH_C   = {1'b1, {ASIZE{1'b0}}};
  localparam logic [ASIZE:0] AFULL_C   = AFULL_TH[ASIZE:0];
  localparam logic [ASIZE:0] AEMPTY_C  = AEMPTY_TH[ASIZE:0];

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic [DSIZE-1:0] mem_q [DEPTH];

  logic [ASIZE:0]   wptr_q,   wptr_d;
  logic [ASIZE:0]   rptr_q,   rptr_d;
  logic [ASIZE:0]   count_q,  count_d;
  logic [DSIZE-1:0] rdata_q,  rdata_d;
  logic             wfull_q,  wfull_d;
  logic             rempty_q, rempty_d;
  logic             afull_q,  afull_d;
  logic             aempty_q, aempty_d;

  logic             rd_acc;
  logic             wr_acc;
  logic [ASIZE-1:0] waddr;
  logic [ASIZE-1:0] raddr;

  assign waddr = wptr_q[ASIZE-1:0];
  assign raddr = rptr_q[ASIZE-1:0];

  // -------------------------------------------------------------------------
  // Request acceptance
  // A write into a full FIFO is still taken when a read frees a slot in the
  // same cycle; the write then lands in the slot the read is vacating, and
  // the read sees the old contents because the memory updates on the edge.
  // flush discards both requests.
  // -------------------------------------------------------------------------
  always_comb begin
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    if (!flush) begin
      rd_acc = rinc && !rempty_q;
      wr_acc = winc && (!wfull_q || rd_acc);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state: pointers, count, read data and flags
  // Flags come from the next-state count so they change on the same edge as
  // count itself.
  // -------------------------------------------------------------------------
  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    rdata_d = rdata_q;

    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (wr_acc) begin
        wptr_d = wptr_q + ONE_C;
      end
      if (rd_acc) begin
        rptr_d  = rptr_q + ONE_C;
        rdata_d = mem_q[raddr];
      end
      unique case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
    end

    wfull_d  = (count_d == DEPTH_C);
    rempty_d = (count_d == '0);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      rdata_q  <= '0;
      wfull_q  <= 1'b0;
      rempty_q <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      rdata_q  <= rdata_d;
      wfull_q  <= wfull_d;
      rempty_q <= rempty_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
    end
  end

  // Storage is deliberately not reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata        = rdata_q;
  assign wfull        = wfull_q;
  assign rempty       = rempty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = count_q;

`ifdef SYNC_FIFO_ERR_FLAGS_EN
  // -------------------------------------------------------------------------
  // Sticky error flags. A new event in the same cycle as err_clr keeps the
  // flag set. Requests discarded by flush are not counted as errors.
  // -------------------------------------------------------------------------
  logic ovf_q, ovf_d;
  logic udf_q, udf_d;
  logic ovf_set;
  logic udf_set;

  always_comb begin
    ovf_set = !flush && winc && !wr_acc;
    udf_set = !flush && rinc && rempty_q;
    ovf_d   = ovf_set || (ovf_q && !err_clr);
    udf_d   = udf_set || (udf_q && !err_clr);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`endif

endmodule

// File: doc/sync_fifo_prog.md
Name: sync_fifo_prog

Overview:
Single-clock, parametrised successor to the dual-clock fifo2 buffer, for blocks that share one clock domain.
- Power-of-two depth, configurable data width.
- Occupancy count output.
- Programmable almost-full / almost-empty thresholds.
- Synchronous flush.
- Registered read data.
- Sits between same-clock producer/consumer stages; no pointer synchronisers.

Parameters:
DSIZE, 8, data width in bits
ASIZE, 6, address width; depth = 2**ASIZE entries
AFULL_TH, 56, almost_full asserted when count >= AFULL_TH (1..2**ASIZE)
AEMPTY_TH, 8, almost_empty asserted when count <= AEMPTY_TH (0..2**ASIZE-1)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
wdata  input  DSIZE  write data
winc  input  1  write request
rinc  input  1  read request
flush  input  1  synchronous clear of contents
rdata  output  DSIZE  registered read data
wfull  output  1  FIFO holds 2**ASIZE entries
rempty  output  1  FIFO holds 0 entries
almost_full  output  1  count >= AFULL_TH
almost_empty  output  1  count <= AEMPTY_TH
count  output  ASIZE+1  current occupancy, 0..2**ASIZE

Behaviour:
- Reset (rst_n low, asynchronous, any time):
  - Pointers and count cleared to 0.
  - rdata = 0, rempty = 1, wfull = 0, almost_full = 0, almost_empty = 1.
  - Memory contents are not cleared.
- Pointers: wptr and rptr are ASIZE+1 bits; the MSB is the wrap bit.
  - Empty when wptr == rptr.
  - Full when addresses are equal and wrap bits differ.
  - Natural binary wrap at 2**ASIZE.
- Write accept: winc && (!wfull || read_accept).
  - mem[wptr[ASIZE-1:0]] <= wdata; wptr increments.
- Read accept: rinc && !rempty.
  - rdata <= mem[rptr[ASIZE-1:0]]; rptr increments.
  - rdata is valid the cycle after the accepting edge.
  - rdata holds its value when no read is accepted.
- Simultaneous winc and rinc:
  - When empty: the write is accepted, the read is ignored; count 0 -> 1.
  - When full: both are accepted; count stays 2**ASIZE and the write lands in the slot being freed.
  - Otherwise: both are accepted; count unchanged.
- Ignored requests:
  - Write when full with no read accepted: data dropped, no state change.
  - Read when empty: rdata unchanged, no state change.
- count: registered; +1 on write-only, -1 on read-only, unchanged on both or neither. It never exceeds 2**ASIZE and never underflows.
- Flags: all registered and derived from next-state count, so they are valid in the same cycle as count.
  - Examples: wfull rises on the edge accepting the 2**ASIZE-th entry; rempty rises on the edge accepting the last read.
- flush:
  - Pointers and count go to 0; flags take their reset values.
  - Has priority over winc/rinc in the same cycle; those requests are discarded.
  - rdata is retained.
- No state machine beyond the pointer/count registers; the design is fully synchronous apart from rst_n.

Optional Feature:
Macro: SYNC_FIFO_ERR_FLAGS_EN
- Defined:
  - Adds outputs overflow (1), underflow (1) and input err_clr (1).
  - overflow sets sticky on a dropped write; underflow sets sticky on an ignored read.
  - Both clear on err_clr or rst_n low; a set in the same cycle as err_clr wins.
  - flush does not clear them.
- Undefined: these ports and registers are absent; dropped and ignored requests are silent.

Test Plan:
- Reset, then write 1..64 on consecutive cycles (DSIZE=8, ASIZE=6) -> wfull rises after the 64th write; count = 64; almost_full first high at count = 56.
- Full FIFO, write 0xAA with no read -> dropped; count stays 64; the next 64 reads return 1..64 in order; rempty rises after the 64th read; rdata = 64.
- Full FIFO, winc+rinc together for 10 cycles with wdata 0x80..0x89 -> count stays 64, wfull stays 1; after draining, the last 10 values read are 0x80..0x89.
- Empty FIFO, winc+rinc with wdata 0x33 -> count 1, rempty 0, rdata unchanged; the next read returns 0x33.
- 20 entries stored, assert flush together with winc -> count 0, rempty 1, almost_empty 1; the write is discarded; rdata retained. Repeat with rst_n pulsed low mid-burst -> all outputs take reset values immediately, without waiting for a clock edge.
- SYNC_FIFO_ERR_FLAGS_EN defined:
  - Read when empty -> underflow = 1 next cycle.
  - Write when full -> overflow = 1.
  - err_clr -> both 0.
